// File: rtl/axi_write_arbiter_if.sv
// axi_write_arbiter_if
//   Handshake and steering bundle between the AXI bridge and its
//   write-path arbiter.
//   Ports (all carried as interface signals):
//     AWVALID_M, AWADDR_M, WVALID_M, WLAST_M, BREADY_M : per real master
//     AWREADY_S, WREADY_S, BVALID_S                    : per slave, default slave included
//     SWIdx : owning master per slave (NUM_M when free)
//     MWIdx : granted slave per master (NUM_S+1 when idle)
//   Modports:
//     master : bridge side, drives handshakes and reads the indices
//     slave  : arbiter side, reads handshakes and drives the indices
interface axi_write_arbiter_if #(
  parameter int NUM_M     = 3,
  parameter int NUM_S     = 6,
  parameter int MIDX_BITS = 2,
  parameter int SIDX_BITS = 3
) ();
  logic [NUM_M-1:0]                 AWVALID_M;
  logic [NUM_M-1:0][31:0]           AWADDR_M;
  logic [NUM_M-1:0]                 WVALID_M;
  logic [NUM_M-1:0]                 WLAST_M;
  logic [NUM_M-1:0]                 BREADY_M;
  logic [NUM_S:0]                   AWREADY_S;
  logic [NUM_S:0]                   WREADY_S;
  logic [NUM_S:0]                   BVALID_S;
  logic [NUM_S:0][MIDX_BITS-1:0]    SWIdx;
  logic [NUM_M-1:0][SIDX_BITS-1:0]  MWIdx;

  modport master (
    output AWVALID_M, AWADDR_M, WVALID_M, WLAST_M, BREADY_M,
    output AWREADY_S, WREADY_S, BVALID_S,
    input  SWIdx, MWIdx
  );

  modport slave (
    input  AWVALID_M, AWADDR_M, WVALID_M, WLAST_M, BREADY_M,
    input  AWREADY_S, WREADY_S, BVALID_S,
    output SWIdx, MWIdx
  );
endinterface

// File: rtl/axi_write_arbiter.sv
// axi_write_arbiter
//   Write-path arbiter for the AXI bridge. Decodes each master's AW
//   address, grants a slave to at most one master at a time and holds
//   the grant through the AW, W and B phases of one transaction. The
//   registered SWIdx/MWIdx outputs steer the bridge's write multiplexer.
//   Ports:
//     ACLK    : clock, rising edge
//     ARESETn : asynchronous active-low reset
//     bus     : axi_write_arbiter_if.slave (handshakes in, SWIdx/MWIdx out)
//   Build option:
//     WARB_ROUND_ROBIN_EN defined   -> per-slave round-robin pointer
//     WARB_ROUND_ROBIN_EN undefined -> fixed priority, lowest master wins
//
//   Per-master FSM:
//   state   | meaning
//   --------+-------------------------------------------------
//   ST_IDLE | no grant; may request the slave its address decodes to
//   ST_AW   | granted; waiting for the AW handshake
//   ST_W    | AW done; waiting for the WLAST beat
//   ST_B    | W done; waiting for the B handshake, then release
module axi_write_arbiter #(
  parameter int NUM_M     = 3,
  parameter int NUM_S     = 6,
  parameter int MIDX_BITS = 2,
  parameter int SIDX_BITS = 3
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  axi_write_arbiter_if.slave bus
);

  localparam int NSLV = NUM_S + 1;          // real slaves plus default slave
  localparam int SEXT = 1 << SIDX_BITS;     // every encodable slave index
  localparam logic [MIDX_BITS-1:0] M_FREE = MIDX_BITS'(NUM_M);
  localparam logic [SIDX_BITS-1:0] S_IDLE = SIDX_BITS'(NUM_S + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} state_e;

  state_e               state_q [NUM_M];
  logic [SIDX_BITS-1:0] mw_q    [NUM_M];
  logic [MIDX_BITS-1:0] sw_q    [NSLV];
  logic [NSLV-1:0]      busy_q;
`ifdef WARB_ROUND_ROBIN_EN
  logic [MIDX_BITS-1:0] ptr_q   [NSLV];
`endif

  function automatic logic [SIDX_BITS-1:0] decode(input logic [31:0] a);
    if (a <= 32'h0000_3FFF)                          return SIDX_BITS'(0);
    if (a >= 32'h0001_0000 && a <= 32'h0001_FFFF)    return SIDX_BITS'(1);
    if (a >= 32'h0002_0000 && a <= 32'h0002_FFFF)    return SIDX_BITS'(2);
    if (a >= 32'h1002_0000 && a <= 32'h1002_03FF)    return SIDX_BITS'(3);
    if (a >= 32'h1001_0000 && a <= 32'h1001_03FF)    return SIDX_BITS'(4);
    if (a >= 32'h2000_0000 && a <= 32'h201F_FFFF)    return SIDX_BITS'(5);
    return SIDX_BITS'(NUM_S);
  endfunction

  // Zero-extended so the idle code (dummy slave) always reads as 0.
  logic [SEXT-1:0] awready_x, wready_x, bvalid_x;
  assign awready_x = SEXT'(bus.AWREADY_S);
  assign wready_x  = SEXT'(bus.WREADY_S);
  assign bvalid_x  = SEXT'(bus.BVALID_S);

  logic [SIDX_BITS-1:0] dec     [NUM_M];
  logic [NUM_M-1:0]     rel_m;
  logic [NSLV-1:0]      rel_s;

  always_comb begin
    rel_s = '0;
    for (int m = 0; m < NUM_M; m++) begin
      dec[m]   = decode(bus.AWADDR_M[m]);
      rel_m[m] = (state_q[m] == ST_B) && bvalid_x[mw_q[m]] && bus.BREADY_M[m];
    end
    for (int m = 0; m < NUM_M; m++)
      for (int s = 0; s < NSLV; s++)
        if (rel_m[m] && mw_q[m] == SIDX_BITS'(s)) rel_s[s] = 1'b1;
  end

  logic [NSLV-1:0]      win_v;
  logic [MIDX_BITS-1:0] win_idx [NSLV];
  logic [NUM_M-1:0]     gnt_m;
  logic [SIDX_BITS-1:0] gnt_slv [NUM_M];

  // A master only ever requests the one slave it decodes to, so each
  // master can win at most one slave per cycle.
  always_comb begin
    int c;
    c = 0;
    for (int s = 0; s < NSLV; s++) begin
      win_v[s]   = 1'b0;
      win_idx[s] = M_FREE;
      if (!busy_q[s] && !rel_s[s]) begin
        for (int k = 0; k < NUM_M; k++) begin
`ifdef WARB_ROUND_ROBIN_EN
          c = (int'(ptr_q[s]) + k) % NUM_M;
`else
          c = k;
`endif
          if (!win_v[s] && state_q[c] == ST_IDLE && bus.AWVALID_M[c] &&
              dec[c] == SIDX_BITS'(s)) begin
            win_v[s]   = 1'b1;
            win_idx[s] = MIDX_BITS'(c);
          end
        end
      end
    end
    for (int m = 0; m < NUM_M; m++) begin
      gnt_m[m]   = 1'b0;
      gnt_slv[m] = S_IDLE;
      for (int s = 0; s < NSLV; s++)
        if (win_v[s] && win_idx[s] == MIDX_BITS'(m)) begin
          gnt_m[m]   = 1'b1;
          gnt_slv[m] = SIDX_BITS'(s);
        end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int m = 0; m < NUM_M; m++) begin
        state_q[m] <= ST_IDLE;
        mw_q[m]    <= S_IDLE;
      end
      for (int s = 0; s < NSLV; s++) begin
        sw_q[s]   <= M_FREE;
        busy_q[s] <= 1'b0;
`ifdef WARB_ROUND_ROBIN_EN
        ptr_q[s]  <= '0;
`endif
      end
    end else begin
      for (int m = 0; m < NUM_M; m++) begin
        case (state_q[m])
          ST_IDLE: if (gnt_m[m]) begin
            state_q[m] <= ST_AW;
            mw_q[m]    <= gnt_slv[m];
          end
          ST_AW: if (bus.AWVALID_M[m] && awready_x[mw_q[m]])
            state_q[m] <= ST_W;
          ST_W: if (bus.WVALID_M[m] && wready_x[mw_q[m]] && bus.WLAST_M[m])
            state_q[m] <= ST_B;
          ST_B: if (rel_m[m]) begin
            state_q[m] <= ST_IDLE;
            mw_q[m]    <= S_IDLE;
          end
          default: state_q[m] <= ST_IDLE;
        endcase
      end
      for (int s = 0; s < NSLV; s++) begin
        if (rel_s[s]) begin
          busy_q[s] <= 1'b0;
          sw_q[s]   <= M_FREE;
        end else if (win_v[s]) begin
          busy_q[s] <= 1'b1;
          sw_q[s]   <= win_idx[s];
`ifdef WARB_ROUND_ROBIN_EN
          ptr_q[s]  <= MIDX_BITS'((int'(win_idx[s]) + 1) % NUM_M);
`endif
        end
      end
    end
  end

  for (genvar g = 0; g < NSLV; g++) begin : g_sw
    assign bus.SWIdx[g] = sw_q[g];
  end
  for (genvar g = 0; g < NUM_M; g++) begin : g_mw
    assign bus.MWIdx[g] = mw_q[g];
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// tb_axi_write_arbiter
//   Directed bench for axi_write_arbiter: reset values, single write,
//   contention order, parallel grants, decode ranges and misses,
//   release-to-regrant gap and asynchronous reset mid-burst.
module tb_axi_write_arbiter;

  localparam int NUM_M = 3;
  localparam int NUM_S = 6;
  localparam int MIDX_BITS = 2;
  localparam int SIDX_BITS = 3;
  localparam int M_FREE = NUM_M;
  localparam int S_IDLE = NUM_S + 1;

  logic aclk;
  logic aresetn;
  int   n_assert;
  int   n_fail;

  axi_write_arbiter_if #(.NUM_M(NUM_M), .NUM_S(NUM_S),
                         .MIDX_BITS(MIDX_BITS), .SIDX_BITS(SIDX_BITS)) bus ();

  axi_write_arbiter #(.NUM_M(NUM_M), .NUM_S(NUM_S),
                      .MIDX_BITS(MIDX_BITS), .SIDX_BITS(SIDX_BITS)) dut (
    .ACLK    (aclk),
    .ARESETn (aresetn),
    .bus     (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called right after the grant edge of master m on slave s.
  task automatic run_txn(input int m, input int s, input int beats, input bit keep_aw);
    tick();
    if (!keep_aw) bus.AWVALID_M[m] = 1'b0;
    bus.WVALID_M[m] = 1'b1;
    for (int b = 0; b < beats; b++) begin
      bus.WLAST_M[m] = (b == beats - 1);
      tick();
    end
    bus.WVALID_M[m] = 1'b0;
    bus.WLAST_M[m]  = 1'b0;
    check("hold_mw", 32'(bus.MWIdx[m]), 32'(s));
    bus.BVALID_S[s] = 1'b1;
    tick();
    bus.BVALID_S[s] = 1'b0;
  endtask

  logic [31:0] dec_addr [10];
  int          dec_exp  [10];
  int          order    [4];

  initial begin
    n_assert = 0;
    n_fail   = 0;
    bus.AWVALID_M = '0;
    bus.AWADDR_M  = '0;
    bus.WVALID_M  = '0;
    bus.WLAST_M   = '0;
    bus.BREADY_M  = '1;
    bus.AWREADY_S = '1;
    bus.WREADY_S  = '1;
    bus.BVALID_S  = '0;
    aresetn = 1'b0;

    // reset values
    #12;
    for (int s = 0; s <= NUM_S; s++) check("rst_sw", 32'(bus.SWIdx[s]), M_FREE);
    for (int m = 0; m < NUM_M; m++)  check("rst_mw", 32'(bus.MWIdx[m]), S_IDLE);
    aresetn = 1'b1;
    tick();

    // single 4-beat write M1 -> DM; address change after grant is ignored
    bus.AWADDR_M[1]  = 32'h0002_0010;
    bus.AWVALID_M[1] = 1'b1;
    tick();
    check("single_sw2", 32'(bus.SWIdx[2]), 1);
    check("single_mw1", 32'(bus.MWIdx[1]), 2);
    bus.AWADDR_M[1]  = 32'h2000_0000;
    run_txn(1, 2, 4, 1'b0);
    check("single_rel_sw2", 32'(bus.SWIdx[2]), M_FREE);
    check("single_rel_mw1", 32'(bus.MWIdx[1]), S_IDLE);

    // contention on DRAM, back-to-back single-beat writes
`ifdef WARB_ROUND_ROBIN_EN
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 0;
`else
    order[0] = 0; order[1] = 0; order[2] = 0; order[3] = 0;
`endif
    for (int m = 0; m < NUM_M; m++) bus.AWADDR_M[m] = 32'h2000_0000;
    bus.AWVALID_M = '1;
    tick();
    check("cont_sw5_0", 32'(bus.SWIdx[5]), order[0]);
    check("cont_mw_0", 32'(bus.MWIdx[order[0]]), 5);
    for (int i = 0; i < 4; i++) begin
      run_txn(order[i], 5, 1, 1'b1);
      check("cont_gap", 32'(bus.SWIdx[5]), M_FREE);
      if (i < 3) begin
        tick();
        check("cont_sw5", 32'(bus.SWIdx[5]), order[i+1]);
      end else begin
        bus.AWVALID_M = '0;
        tick();
        check("cont_end", 32'(bus.SWIdx[5]), M_FREE);
      end
    end

    // parallel grants on the same edge
    bus.AWADDR_M[0]  = 32'h0001_0000;
    bus.AWADDR_M[2]  = 32'h0002_0004;
    bus.AWVALID_M[0] = 1'b1;
    bus.AWVALID_M[2] = 1'b1;
    tick();
    check("par_sw1", 32'(bus.SWIdx[1]), 0);
    check("par_sw2", 32'(bus.SWIdx[2]), 2);
    check("par_mw0", 32'(bus.MWIdx[0]), 1);
    check("par_mw2", 32'(bus.MWIdx[2]), 2);
    tick();
    bus.AWVALID_M = '0;
    bus.WVALID_M[0] = 1'b1; bus.WLAST_M[0] = 1'b1;
    bus.WVALID_M[2] = 1'b1; bus.WLAST_M[2] = 1'b1;
    tick();
    bus.WVALID_M = '0;
    bus.WLAST_M  = '0;
    bus.BVALID_S[1] = 1'b1;
    bus.BVALID_S[2] = 1'b1;
    tick();
    bus.BVALID_S = '0;
    check("par_rel_sw1", 32'(bus.SWIdx[1]), M_FREE);
    check("par_rel_sw2", 32'(bus.SWIdx[2]), M_FREE);
    check("par_rel_mw0", 32'(bus.MWIdx[0]), S_IDLE);
    check("par_rel_mw2", 32'(bus.MWIdx[2]), S_IDLE);

    // decode miss to default slave, completes and releases
    bus.AWADDR_M[1]  = 32'h3000_0000;
    bus.AWVALID_M[1] = 1'b1;
    tick();
    check("miss_mw1", 32'(bus.MWIdx[1]), 6);
    check("miss_sw6", 32'(bus.SWIdx[6]), 1);
    run_txn(1, 6, 2, 1'b0);
    check("miss_rel_sw6", 32'(bus.SWIdx[6]), M_FREE);
    check("miss_rel_mw1", 32'(bus.MWIdx[1]), S_IDLE);

    // decode range edges
    dec_addr[0] = 32'h0000_3FFF; dec_exp[0] = 0;
    dec_addr[1] = 32'h0000_4000; dec_exp[1] = 6;
    dec_addr[2] = 32'h0001_FFFF; dec_exp[2] = 1;
    dec_addr[3] = 32'h0002_FFFF; dec_exp[3] = 2;
    dec_addr[4] = 32'h1002_0000; dec_exp[4] = 3;
    dec_addr[5] = 32'h1002_0400; dec_exp[5] = 6;
    dec_addr[6] = 32'h1001_03FF; dec_exp[6] = 4;
    dec_addr[7] = 32'h201F_FFFF; dec_exp[7] = 5;
    dec_addr[8] = 32'h2020_0000; dec_exp[8] = 6;
    dec_addr[9] = 32'h1001_0000; dec_exp[9] = 4;
    for (int i = 0; i < 10; i++) begin
      bus.AWADDR_M[2]  = dec_addr[i];
      bus.AWVALID_M[2] = 1'b1;
      tick();
      check("dec_mw2", 32'(bus.MWIdx[2]), dec_exp[i]);
      check("dec_sw", 32'(bus.SWIdx[dec_exp[i]]), 2);
      run_txn(2, dec_exp[i], 1, 1'b0);
      check("dec_rel_mw2", 32'(bus.MWIdx[2]), S_IDLE);
    end

    // release gap: M0 waits on S2 owned by M1
    bus.AWADDR_M[1]  = 32'h0002_0000;
    bus.AWVALID_M[1] = 1'b1;
    tick();
    bus.AWADDR_M[0]  = 32'h0002_0008;
    bus.AWVALID_M[0] = 1'b1;
    tick();
    bus.AWVALID_M[1] = 1'b0;
    bus.WVALID_M[1]  = 1'b1;
    bus.WLAST_M[1]   = 1'b1;
    tick();
    bus.WVALID_M[1]  = 1'b0;
    bus.WLAST_M[1]   = 1'b0;
    check("gap_owner", 32'(bus.SWIdx[2]), 1);
    check("gap_wait_mw0", 32'(bus.MWIdx[0]), S_IDLE);
    bus.BVALID_S[2] = 1'b1;
    tick();
    bus.BVALID_S[2] = 1'b0;
    check("gap_edge_n_sw2", 32'(bus.SWIdx[2]), M_FREE);
    check("gap_edge_n_mw0", 32'(bus.MWIdx[0]), S_IDLE);
    tick();
    check("gap_edge_n1_sw2", 32'(bus.SWIdx[2]), 0);
    check("gap_edge_n1_mw0", 32'(bus.MWIdx[0]), 2);
    run_txn(0, 2, 1, 1'b0);
    check("gap_rel_sw2", 32'(bus.SWIdx[2]), M_FREE);

    // asynchronous reset during beat 2 of 4
    bus.AWADDR_M[0]  = 32'h2000_0100;
    bus.AWADDR_M[2]  = 32'h0000_0000;
    bus.AWVALID_M[0] = 1'b1;
    bus.AWVALID_M[2] = 1'b1;
    tick();
    check("rw_mw0", 32'(bus.MWIdx[0]), 5);
    check("rw_mw2", 32'(bus.MWIdx[2]), 0);
    tick();
    bus.AWVALID_M   = '0;
    bus.WVALID_M[0] = 1'b1;
    tick();
    #3;
    aresetn = 1'b0;
    #1;
    for (int s = 0; s <= NUM_S; s++) check("rw_sw", 32'(bus.SWIdx[s]), M_FREE);
    for (int m = 0; m < NUM_M; m++)  check("rw_mw", 32'(bus.MWIdx[m]), S_IDLE);
    bus.WVALID_M = '0;
    #1;
    aresetn = 1'b1;
    tick();
    check("rw_idle_sw5", 32'(bus.SWIdx[5]), M_FREE);
    // fresh grants prove both FSMs came back to IDLE
    bus.AWADDR_M[0]  = 32'h0001_0000;
    bus.AWADDR_M[2]  = 32'h0000_0010;
    bus.AWVALID_M[0] = 1'b1;
    bus.AWVALID_M[2] = 1'b1;
    tick();
    check("post_rst_mw0", 32'(bus.MWIdx[0]), 1);
    check("post_rst_mw2", 32'(bus.MWIdx[2]), 0);
    run_txn(0, 1, 1, 1'b0);
    check("post_rst_rel_mw0", 32'(bus.MWIdx[0]), S_IDLE);
    run_txn(2, 0, 1, 1'b0);
    check("post_rst_rel_sw0", 32'(bus.SWIdx[0]), M_FREE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_write_arbiter.md
# axi_write_arbiter

Write-path arbiter and router controller for the AXI bridge. Decodes each master's AW address, grants slaves to masters per slave, and holds each grant through the AW, W and B phases of one transaction. Drives the per-slave master index (`SWIdx`) and per-master slave index (`MWIdx`) that steer the bridge's combinational write multiplexer.

## Interface
- `NUM_M`, 3: number of real masters; index `NUM_M` is the padded dummy master with all inputs tied 0.
- `NUM_S`, 6: number of real slaves; index `NUM_S` is the default (decode-error) slave; index `NUM_S+1` is the dummy slave with all outputs tied 0.
- `MIDX_BITS`, 2: width of a master index; must hold `NUM_M`.
- `SIDX_BITS`, 3: width of a slave index; must hold `NUM_S+1`.

Ports:
- `ACLK` in 1: clock; all state updates on rising edge.
- `ARESETn` in 1: asynchronous, active-low reset.
- `AWVALID_M` in `NUM_M`: AW valid per master.
- `AWADDR_M` in `NUM_M`×32: AW address per master.
- `WVALID_M`, `WLAST_M`, `BREADY_M` in `NUM_M` each: master W/B handshake signals.
- `AWREADY_S`, `WREADY_S`, `BVALID_S` in `NUM_S+1` each: slave handshake signals, default slave included.
- `SWIdx` out `NUM_S+1`×`MIDX_BITS`: owning master per slave; `NUM_M` when free.
- `MWIdx` out `NUM_M`×`SIDX_BITS`: granted slave per master; `NUM_S+1` when idle.

## Operation
- Address decode (combinational, per master): S0 ROM `0x0000_0000`–`0x0000_3FFF`; S1 IM `0x0001_0000`–`0x0001_FFFF`; S2 DM `0x0002_0000`–`0x0002_FFFF`; S3 DMA `0x1002_0000`–`0x1002_03FF`; S4 WDT `0x1001_0000`–`0x1001_03FF`; S5 DRAM `0x2000_0000`–`0x201F_FFFF`; anything else maps to `NUM_S`. Ranges are inclusive.
- Per-master FSM with states IDLE, AW, W and B:
  - IDLE→AW on grant.
  - AW→W when `AWVALID_M & AWREADY_S[MWIdx]`.
  - W→B when `WVALID_M & WREADY_S[MWIdx] & WLAST_M`.
  - B→IDLE when `BVALID_S[MWIdx] & BREADY_M`. On this transition the slave is released (`SWIdx`←`NUM_M`) and `MWIdx`←`NUM_S+1`.
- Per-slave busy flag: set on grant, cleared on release.
- Grant condition, evaluated every cycle for each slave `s`:
  - `s` is not busy, and was not released this cycle.
  - At least one master is in IDLE with `AWVALID_M` high and decodes to `s`.
  - On grant, the winner is registered into `SWIdx[s]` and `MWIdx[m]`.
- Multiple slaves may be granted in the same cycle, to different masters.
- A master holds at most one grant; there are no outstanding or interleaved transactions.
- `AWADDR_M` is sampled only in IDLE. Changes while in AW, W or B are ignored.

## Timing
- Reset (asynchronous assert): all FSMs IDLE, all busy flags 0, `SWIdx[*]`=`NUM_M`, `MWIdx[*]`=`NUM_S+1`, RR pointers 0.
- Grant latency: `AWVALID_M` high at edge N (master IDLE, slave free) gives updated indices after edge N. The bridge presents `AWVALID_S` in cycle N+1. The earliest AW handshake is at edge N+1.
- Release-to-regrant: B handshake at edge N frees the slave after N. A new grant to that slave occurs no earlier than edge N+1, giving exactly one idle cycle.
- Same-edge handshakes:
  - AW and W handshakes may not occur on the same edge; W is qualified only in state W.
  - A single-beat W (WLAST) completes in one W cycle.
- Reset mid-transaction: all grants drop immediately. No B is owed after reset.

## Configuration
- `WARB_ROUND_ROBIN_EN` defined:
  - Each slave keeps a pointer P. The search starts at master P and proceeds upward mod `NUM_M`.
  - After granting master m, P←(m+1) mod `NUM_M`.
- Undefined: fixed priority, where the lowest master index wins. No pointers are instantiated.

## Test plan
- Single write: M1 writes to `0x0002_0010` with AWLEN=3.
  - Edge after AWVALID: `SWIdx[2]`=1, `MWIdx[1]`=2.
  - After the B handshake: `SWIdx[2]`=3, `MWIdx[1]`=7.
- Contention, with `WARB_ROUND_ROBIN_EN`: M0, M1 and M2 hold AWVALID to DRAM `0x2000_0000` and complete back-to-back.
  - Required grant order: 0, 1, 2, 0.
  - Without the macro, M0 wins every time.
- Parallel: M0 targets IM `0x0001_0000` and M2 targets DM `0x0002_0004` in the same cycle. Both are granted on the same edge.
- Decode miss: M1 writes to `0x3000_0000`.
  - Result: `MWIdx[1]`=6, `SWIdx[6]`=1.
  - The transaction completes against the default slave and releases normally.
- Release gap: M0 holds AWVALID to S2 while M1 owns S2.
  - B handshake at edge N.
  - M0 is granted at edge N+1, not N.
- Reset mid-W: assert `ARESETn`=0 during beat 2 of 4. All indices return immediately to `NUM_M`/`NUM_S+1` and all FSMs return to IDLE.
